// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage LoongArch-style pipeline.
// Latches EX results, extracts load data, holds it across WB stalls.
module mem_stage #(
  parameter int EX_BUS_W = 108,
  parameter int WB_BUS_W = 70,
  parameter int ID_BUS_W = 38
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                ex_to_mem_valid,
  input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [WB_BUS_W-1:0] mem_to_wb_bus,
  output logic [ID_BUS_W-1:0] mem_to_id_bus,
  input  logic [31:0]         data_sram_rdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [1:0]  addr_low;
    logic        op_b;
    logic        op_h;
    logic        op_u;
  } ex_mem_t;

  ex_mem_t     w_ex;
  logic        w_unused;
  logic        w_allowin;
  logic        w_cap;
  logic [31:0] w_eff;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata;
  logic        w_we;

  logic        r_valid;
  logic        r_first;
  logic [31:0] r_rbuf;
  logic [31:0] r_pc;
  logic        r_res_from_mem;
  logic        r_rf_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_alu;
  logic [1:0]  r_addr_low;
  logic        r_op_b;
  logic        r_op_h;
  logic        r_op_u;

  assign w_ex     = ex_to_mem_bus;
  assign w_unused = ^w_ex.rkd_value;

  assign w_allowin = ~r_valid | wb_allowin;
  assign w_cap     = ex_to_mem_valid & w_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid        <= 1'b0;
      r_first        <= 1'b0;
      r_rbuf         <= '0;
      r_pc           <= '0;
      r_res_from_mem <= 1'b0;
      r_rf_we        <= 1'b0;
      r_waddr        <= '0;
      r_alu          <= '0;
      r_addr_low     <= '0;
      r_op_b         <= 1'b0;
      r_op_h         <= 1'b0;
      r_op_u         <= 1'b0;
    end else begin
      if (w_allowin) begin
        r_valid <= ex_to_mem_valid;
      end
      r_first <= w_cap;
      // SRAM data is only valid in the first cycle; keep it for stalls
      if (r_valid & r_first) begin
        r_rbuf <= data_sram_rdata;
      end
      if (w_cap) begin
        r_pc           <= w_ex.pc;
        r_res_from_mem <= w_ex.res_from_mem;
        r_rf_we        <= w_ex.rf_we;
        r_waddr        <= w_ex.rf_waddr;
        r_alu          <= w_ex.alu_result;
        r_addr_low     <= w_ex.addr_low;
        r_op_b         <= w_ex.op_b;
        r_op_h         <= w_ex.op_h;
        r_op_u         <= w_ex.op_u;
      end
    end
  end

  assign w_eff  = r_first ? data_sram_rdata : r_rbuf;
  assign w_byte = w_eff[{r_addr_low, 3'b000} +: 8];
  assign w_half = r_addr_low[1] ? w_eff[31:16] : w_eff[15:0];

  always_comb begin
    w_load = w_eff;
    unique case (1'b1)
      r_op_b:  w_load = {{24{~r_op_u & w_byte[7]}}, w_byte};
      r_op_h:  w_load = {{16{~r_op_u & w_half[15]}}, w_half};
      default: w_load = w_eff;
    endcase
  end

  assign w_wdata = r_res_from_mem ? w_load : r_alu;
  assign w_we    = r_rf_we & r_valid;

  assign mem_allowin     = w_allowin;
  assign mem_to_wb_valid = r_valid;
  assign mem_to_wb_bus   = {r_pc, w_we, r_waddr, w_wdata};
  assign mem_to_id_bus   = {w_we, r_waddr, w_wdata};

endmodule
